// File: rtl/chrono_pkg.sv
// chrono_pkg: shared constants and BCD helpers for the mm:ss.cc chronometer.
// Packing of a 24-bit count is {m1,m0,s1,s0,c1,c0}, one 4-bit BCD digit each,
// with digit index 0 = c0 at bits [3:0] up to index 5 = m1 at bits [23:20].
package chrono_pkg;

    localparam int DIGIT_W = 4;
    localparam int DIGITS  = 6;
    localparam int BCD_W   = DIGIT_W * DIGITS;

    // Digit indices inside the packed count
    localparam int C0_IDX = 0;
    localparam int C1_IDX = 1;
    localparam int S0_IDX = 2;
    localparam int S1_IDX = 3;
    localparam int M0_IDX = 4;
    localparam int M1_IDX = 5;

    localparam logic [3:0] LIM_LO = 4'd9;
    localparam logic [3:0] LIM_HI = 4'd5;

    localparam logic [23:0] BCD_ZERO = 24'h000000;
    localparam logic [23:0] BCD_MAX  = 24'h595999;

    // Largest legal value of a digit: tens of seconds and tens of minutes stop at 5
    function automatic logic [3:0] digit_limit(input int idx);
        case (idx)
            S1_IDX, M1_IDX: return LIM_HI;
            default:        return LIM_LO;
        endcase
    endfunction

    // Saturate every digit to its limit
    function automatic logic [23:0] bcd_clamp(input logic [23:0] v);
        logic [23:0] r;
        logic [3:0]  dig;
        logic [3:0]  lim;
        r = BCD_ZERO;
        for (int i = 0; i < DIGITS; i++) begin
            dig = v[DIGIT_W*i +: DIGIT_W];
            lim = digit_limit(i);
            r[DIGIT_W*i +: DIGIT_W] = (dig > lim) ? lim : dig;
        end
        return r;
    endfunction

    // Ripple-carry increment; a digit at its limit rolls to 0 and carries
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic [3:0]  dig;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = v[DIGIT_W*i +: DIGIT_W];
            if (carry) begin
                if (dig >= digit_limit(i)) begin
                    dig = 4'd0;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            r[DIGIT_W*i +: DIGIT_W] = dig;
        end
        return r;
    endfunction

    // Ripple-borrow decrement; a digit at 0 becomes its limit and borrows
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic [3:0]  dig;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = v[DIGIT_W*i +: DIGIT_W];
            if (borrow) begin
                if (dig == 4'd0) begin
                    dig = digit_limit(i);
                end else begin
                    dig    = dig - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[DIGIT_W*i +: DIGIT_W] = dig;
        end
        return r;
    endfunction

endpackage

// File: rtl/chrono_prescaler.sv
// chrono_prescaler: divides the system clock down to the count rate.
// Ports: ck (clock), rn (async active-low reset), en (count allowed),
//        reload (synchronous restart of the period), tick (registered
//        one-cycle pulse, first one FDIV cycles after counting is allowed).
import chrono_pkg::*;

module chrono_prescaler #(
    parameter int FDIV = 10
) (
    input  logic ck,
    input  logic rn,
    input  logic en,
    input  logic reload,
    output logic tick
);

    localparam int          W   = (FDIV > 1) ? $clog2(FDIV) : 1;
    localparam logic [W-1:0] TOP = W'(FDIV - 1);

    logic [W-1:0] cnt_r;
    logic         tick_r;

    // Down-counter; the pulse is emitted on the edge where the counter sits at zero
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            cnt_r  <= TOP;
            tick_r <= 1'b0;
        end else if (reload || !en) begin
            cnt_r  <= TOP;
            tick_r <= 1'b0;
        end else if (cnt_r == W'(0)) begin
            cnt_r  <= TOP;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r - W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/chrono_lap.sv
// chrono_lap: BCD stopwatch/timer mm:ss.cc with up/down count, preload,
// countdown-done, wrap flag and lap freeze of the displayed value.
// Ports: ck/rn clock and async active-low reset; cl synchronous clear;
//        start run enable; down count direction; load/ld_val preload;
//        lap freeze toggle strobe; t live count; d displayed count;
//        frozen lap active; done countdown reached zero (sticky);
//        wrap up-count rollover pulse; tick prescaler pulse.
import chrono_pkg::*;

module chrono_lap #(
    parameter int FREQ    = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic        ck,
    input  logic        rn,
    input  logic        cl,
    input  logic        start,
    input  logic        down,
    input  logic        load,
    input  logic [23:0] ld_val,
    input  logic        lap,
    output logic [23:0] t,
    output logic [23:0] d,
    output logic        frozen,
    output logic        done,
    output logic        wrap,
    output logic        tick
);

    localparam int FDIV = FREQ / TICK_HZ;

    logic [23:0] t_r;
    logic [23:0] snap_r;
    logic        frozen_r;
    logic        done_r;
    logic        wrap_r;
    logic        tick_s;
    logic [23:0] inc_s;
    logic [23:0] dec_s;
    logic [23:0] ld_clamp_s;

    chrono_prescaler #(.FDIV(FDIV)) u_presc (
        .ck     (ck),
        .rn     (rn),
        .en     (start & ~done_r),
        .reload (cl | load),
        .tick   (tick_s)
    );

    // Next-value candidates for the digit chain
    always_comb begin
        inc_s      = bcd_inc(t_r);
        dec_s      = bcd_dec(t_r);
        ld_clamp_s = bcd_clamp(ld_val);
    end

    // Live count with done/wrap; done also blocks the tick so the count holds
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            t_r    <= BCD_ZERO;
            done_r <= 1'b0;
            wrap_r <= 1'b0;
        end else if (cl) begin
            t_r    <= BCD_ZERO;
            done_r <= 1'b0;
            wrap_r <= 1'b0;
        end else if (load) begin
            t_r    <= ld_clamp_s;
            done_r <= 1'b0;
            wrap_r <= 1'b0;
        end else if (tick_s && !done_r) begin
            if (!down) begin
                t_r    <= inc_s;
                wrap_r <= (t_r == BCD_MAX);
            end else if (t_r == BCD_ZERO) begin
                // Already at zero: flag completion, no underflow
                done_r <= 1'b1;
                wrap_r <= 1'b0;
            end else begin
                t_r    <= dec_s;
                done_r <= (dec_s == BCD_ZERO);
                wrap_r <= 1'b0;
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    // Lap toggle; snapshot takes the count as it stands before this edge's update
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            snap_r   <= BCD_ZERO;
            frozen_r <= 1'b0;
        end else if (cl) begin
            snap_r   <= BCD_ZERO;
            frozen_r <= 1'b0;
        end else if (lap) begin
            if (!frozen_r) begin
                snap_r   <= t_r;
                frozen_r <= 1'b1;
            end else begin
                frozen_r <= 1'b0;
            end
        end else begin
            frozen_r <= frozen_r;
        end
    end

    assign t      = t_r;
    assign d      = frozen_r ? snap_r : t_r;
    assign frozen = frozen_r;
    assign done   = done_r;
    assign wrap   = wrap_r;
    assign tick   = tick_s;

endmodule
